// File: rtl/striping_pkg.sv
// ---------------------------------------------------------------------------
// striping_pkg
// Definitions shared by the byte-striping stage and the unstripping stage
// that later recombines the two lanes.
//   DEF_DATA_WIDTH : default byte / stripe width
//   state_t        : striping FSM states (IDLE waits for the lane-0 byte,
//                    HALF holds lane 0 and waits for its lane-1 partner)
//   HOLD_CYCLES    : fast-clock cycles each emitted pair stays valid
//                    (one slow-clock period)
// ---------------------------------------------------------------------------
package striping_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HALF = 1'b1
   } state_t;

   localparam int HOLD_CYCLES = 2;

endpackage : striping_pkg

// File: rtl/byte_striping.sv
// ---------------------------------------------------------------------------
// byte_striping
// Splits a fast-clock byte stream onto two stripes: even bytes to lane 0,
// odd bytes to lane 1. A completed pair is presented together for
// HOLD_CYCLES fast cycles. A lone lane-0 byte whose partner does not arrive
// within FLUSH_CYCLES idle cycles is emitted by itself.
//
// Ports
//   clk_2f          in   fast clock (only clock)
//   reset_L         in   asynchronous active-low reset
//   data_in         in   incoming byte
//   valid_in        in   data_in carries a byte this cycle
//   data_stripe_0   out  lane 0 byte, held until the next emission
//   data_stripe_1   out  lane 1 byte, held until the next emission (0 on flush)
//   valid_stripe_0  out  lane 0 valid, high for the hold window
//   valid_stripe_1  out  lane 1 valid, high for the hold window of a pair
//   stripe_strobe   out  one-cycle pulse on each new pair or flush
// ---------------------------------------------------------------------------
module byte_striping
   import striping_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic                  clk_2f,
   input  logic                  reset_L,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] data_stripe_0,
   output logic [DATA_WIDTH-1:0] data_stripe_1,
   output logic                  valid_stripe_0,
   output logic                  valid_stripe_1,
   output logic                  stripe_strobe
);

   // Terminal count of the idle counter; the counter leaves HALF here and so
   // never wraps its 4 bits (FLUSH_CYCLES is limited to 1..15).
   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
   localparam logic       HOLD_LOAD  = 1'(HOLD_CYCLES - 1);

   state_t                state, state_nxt;
   logic [3:0]            flush_cnt, flush_cnt_nxt;
   logic [DATA_WIDTH-1:0] hold0;
   logic                  hold_ld;
   logic                  emit_pair, emit_flush;
   logic                  hold_timer;

   // Next-state and emission decode
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      hold_ld       = 1'b0;
      emit_pair     = 1'b0;
      emit_flush    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (valid_in) begin
               hold_ld       = 1'b1;
               flush_cnt_nxt = 4'd0;
               state_nxt     = ST_HALF;
            end
         end
         ST_HALF: begin
            if (valid_in) begin
               emit_pair = 1'b1;
               state_nxt = ST_IDLE;
            end else if (flush_cnt == FLUSH_LAST) begin
               emit_flush = 1'b1;
               state_nxt  = ST_IDLE;
            end else begin
               flush_cnt_nxt = flush_cnt + 4'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         state     <= ST_IDLE;
         flush_cnt <= 4'd0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   // Lane-0 capture register
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         hold0 <= '0;
      end else if (hold_ld) begin
         hold0 <= data_in;
      end
   end

   // Output registers and hold window. The timer is loaded on an emission so
   // the valids survive one further edge; a fresh emission always wins over
   // the timer running out, keeping back-to-back pairs continuously valid.
   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         data_stripe_0  <= '0;
         data_stripe_1  <= '0;
         valid_stripe_0 <= 1'b0;
         valid_stripe_1 <= 1'b0;
         stripe_strobe  <= 1'b0;
         hold_timer     <= 1'b0;
      end else begin
         stripe_strobe <= emit_pair | emit_flush;
         if (emit_pair | emit_flush) begin
            data_stripe_0  <= hold0;
            data_stripe_1  <= emit_pair ? data_in : '0;
            valid_stripe_0 <= 1'b1;
            valid_stripe_1 <= emit_pair;
            hold_timer     <= HOLD_LOAD;
         end else if (hold_timer) begin
            hold_timer <= 1'b0;
         end else begin
            valid_stripe_0 <= 1'b0;
            valid_stripe_1 <= 1'b0;
         end
      end
   end

endmodule : byte_striping
